// File: rtl/irq_gen_pkg.sv
// Shared types for the multi-channel command-FIFO interrupt generator.
// Channel FSM encoding and the per-channel IRQ_MODE bit values.
package irq_gen_pkg;

    typedef enum logic [0:0] {
        IDLE_ST   = 1'b0,
        ACTIVE_ST = 1'b1
    } irq_fsm_t;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

endpackage

// File: rtl/irq_event_channel.sv
// One channel: FIFO-available event detect, pulse/level IRQ FSM, duration counter, pending capture.
// IRQ rises two edges after EMPTY is sampled low; no backpressure, the host services via RDEN/ACK.
module irq_event_channel
    import irq_gen_pkg::*;
#(
    parameter int DURATION_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DURATION_WIDTH-1:0] duration_i,
    input  logic                      mode_i,
    input  logic                      mask_i,
    input  logic                      ack_i,
    input  logic                      cmd_empty_i,
    input  logic                      cmd_rden_i,
    output logic                      irq_o,
    output logic                      pending_o
);

    irq_fsm_t                  state_q, state_d;
    logic [DURATION_WIDTH-1:0] cnt_q, cnt_d;
    logic [DURATION_WIDTH-1:0] dur_last;
    logic                      d_cmd_empty_q, d_cmd_rden_q;
    logic                      evt_q, evt_d;
    logic                      pend_q, pend_d;
    logic                      irq_q, irq_d;
    logic                      exit_c;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = '0;
        irq_d    = 1'b0;
        // A zero DURATION still produces a single-cycle pulse.
        dur_last = (duration_i == '0) ? '0 : duration_i - DURATION_WIDTH'(1);
        evt_d    = !cmd_empty_i & (d_cmd_empty_q | d_cmd_rden_q);
        exit_c   = cmd_rden_i | mask_i
                 | ((mode_i == MODE_LEVEL) & ack_i)
                 | ((mode_i == MODE_PULSE) & (cnt_q == dur_last));

        case (state_q)
            IDLE_ST: begin
                if (mask_i) begin
                    pend_d = 1'b0;
                end else if (evt_q | pend_q) begin
                    state_d = ACTIVE_ST;
                    pend_d  = 1'b0;
                    irq_d   = 1'b1;
                end
            end
            ACTIVE_ST: begin
                // An event that coincides with the exit is kept for the next pulse.
                if (mask_i) begin
                    pend_d = 1'b0;
                end else if (evt_q) begin
                    pend_d = 1'b1;
                end
                if (exit_c) begin
                    state_d = IDLE_ST;
                end else begin
                    irq_d = 1'b1;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + DURATION_WIDTH'(1);
                end
            end
            default: state_d = IDLE_ST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE_ST;
            cnt_q         <= '0;
            d_cmd_empty_q <= 1'b1;
            d_cmd_rden_q  <= 1'b0;
            evt_q         <= 1'b0;
            pend_q        <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            d_cmd_empty_q <= cmd_empty_i;
            d_cmd_rden_q  <= cmd_rden_i;
            evt_q         <= evt_d;
            pend_q        <= pend_d;
            irq_q         <= irq_d;
        end
    end

    assign irq_o     = irq_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/irq_event_generator_mc.sv
// N independent command-FIFO "not-empty" interrupt channels plus a combined IRQ_ANY.
// Per-channel latency and servicing as in irq_event_channel; IRQ_ANY is a pure OR of registers.
module irq_event_generator_mc #(
    parameter int N_CHANNELS     = 4,
    parameter int DURATION_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [DURATION_WIDTH-1:0] DURATION,
    input  logic [N_CHANNELS-1:0]     IRQ_MODE,
    input  logic [N_CHANNELS-1:0]     IRQ_MASK,
    input  logic [N_CHANNELS-1:0]     IRQ_ACK,
    input  logic [N_CHANNELS-1:0]     CMD_EMPTY,
    input  logic [N_CHANNELS-1:0]     CMD_RDEN,
    output logic [N_CHANNELS-1:0]     CMD_EMPTY_IMPULSE,
    output logic [N_CHANNELS-1:0]     IRQ_PENDING,
    output logic                      IRQ_ANY
);

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
        irq_event_channel #(
            .DURATION_WIDTH(DURATION_WIDTH)
        ) u_ch (
            .clk        (CLK),
            .rst        (RESET),
            .duration_i (DURATION),
            .mode_i     (IRQ_MODE[gi]),
            .mask_i     (IRQ_MASK[gi]),
            .ack_i      (IRQ_ACK[gi]),
            .cmd_empty_i(CMD_EMPTY[gi]),
            .cmd_rden_i (CMD_RDEN[gi]),
            .irq_o      (CMD_EMPTY_IMPULSE[gi]),
            .pending_o  (IRQ_PENDING[gi])
        );
    end

    assign IRQ_ANY = |CMD_EMPTY_IMPULSE;

endmodule

// File: tb/tb_irq_event_generator_mc.sv
// Directed bench: stimulus queues per-cycle expected output snapshots, a negedge monitor checks them.
module tb_irq_event_generator_mc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] DURATION = 32'd4;
    logic [3:0]  IRQ_MODE = '0;
    logic [3:0]  IRQ_MASK = '0;
    logic [3:0]  IRQ_ACK = '0;
    logic [3:0]  CMD_EMPTY = 4'hF;
    logic [3:0]  CMD_RDEN = '0;
    logic [3:0]  CMD_EMPTY_IMPULSE;
    logic [3:0]  IRQ_PENDING;
    logic        IRQ_ANY;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] imp;
        logic [3:0] pend;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    irq_event_generator_mc #(.N_CHANNELS(4), .DURATION_WIDTH(32)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DURATION         (DURATION),
        .IRQ_MODE         (IRQ_MODE),
        .IRQ_MASK         (IRQ_MASK),
        .IRQ_ACK          (IRQ_ACK),
        .CMD_EMPTY        (CMD_EMPTY),
        .CMD_RDEN         (CMD_RDEN),
        .CMD_EMPTY_IMPULSE(CMD_EMPTY_IMPULSE),
        .IRQ_PENDING      (IRQ_PENDING),
        .IRQ_ANY          (IRQ_ANY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got {imp,pend,any}=%h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic exp_at(input int c, input logic [3:0] imp, input logic [3:0] pend, input string nm);
        exp_t e;
        e.cyc = c; e.imp = imp; e.pend = pend; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic exp_span(input int c0, input int c1, input logic [3:0] imp,
                            input logic [3:0] pend, input string nm);
        for (int c = c0; c <= c1; c++) exp_at(c, imp, pend, nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: snapshot for cycle %0d missed, now at cycle %0d", mon_e.nm, mon_e.cyc, cyc);
                end else begin
                    check($sformatf("%s@%0d", mon_e.nm, mon_e.cyc),
                          {CMD_EMPTY_IMPULSE, IRQ_PENDING, IRQ_ANY},
                          {mon_e.imp, mon_e.pend, |mon_e.imp});
                end
            end
        end
    end

    initial begin
        int b;
        step(3);
        check("reset_state", {CMD_EMPTY_IMPULSE, IRQ_PENDING, IRQ_ANY}, 9'h0);
        RESET = 1'b0;

        // 1: ch0 pulse, DURATION=4
        step(2); b = cyc;
        exp_at(b + 1, 4'h0, 4'h0, "t1_evt");
        exp_span(b + 2, b + 5, 4'h1, 4'h0, "t1_pulse");
        exp_span(b + 6, b + 7, 4'h0, 4'h0, "t1_end");
        CMD_EMPTY[0] = 1'b0;
        step(8); CMD_EMPTY[0] = 1'b1;

        // 2: ch1 pulse DURATION=8, serviced by a read in its third cycle
        step(2); b = cyc;
        DURATION = 32'd8;
        exp_at(b + 1, 4'h0, 4'h0, "t2_evt");
        exp_span(b + 2, b + 4, 4'h2, 4'h0, "t2_pulse");
        exp_span(b + 5, b + 7, 4'h0, 4'h0, "t2_read_end");
        CMD_EMPTY[1] = 1'b0;
        step(4); CMD_RDEN[1] = 1'b1; CMD_EMPTY[1] = 1'b1;
        step(1); CMD_RDEN[1] = 1'b0;
        step(3);

        // 3: ch2 level mode held for 100 cycles, released by ACK
        step(1); b = cyc;
        exp_at(b + 1, 4'h0, 4'h0, "t3_evt");
        exp_at(b + 2, 4'h4, 4'h0, "t3_rise");
        exp_at(b + 50, 4'h4, 4'h0, "t3_held");
        exp_at(b + 101, 4'h4, 4'h0, "t3_held_late");
        exp_span(b + 102, b + 103, 4'h0, 4'h0, "t3_ack");
        IRQ_MODE[2] = 1'b1; CMD_EMPTY[2] = 1'b0;
        step(101); IRQ_ACK[2] = 1'b1;
        step(1); IRQ_ACK[2] = 1'b0;
        step(1); CMD_EMPTY[2] = 1'b1;
        step(2);

        // 4: ch0 DURATION=10: read with data left, re-fire, pending capture, ACK ignored in pulse mode
        step(1); b = cyc;
        DURATION = 32'd10;
        exp_at(b + 1, 4'h0, 4'h0, "t4_evt");
        exp_span(b + 2, b + 4, 4'h1, 4'h0, "t4_first");
        exp_span(b + 5, b + 6, 4'h0, 4'h0, "t4_gap");
        exp_span(b + 7, b + 11, 4'h1, 4'h0, "t4_second");
        exp_span(b + 12, b + 16, 4'h1, 4'h1, "t4_pending");
        exp_at(b + 17, 4'h0, 4'h1, "t4_idle_pend");
        exp_span(b + 18, b + 27, 4'h1, 4'h0, "t4_refire");
        exp_span(b + 28, b + 29, 4'h0, 4'h0, "t4_end");
        CMD_EMPTY[0] = 1'b0;
        step(4); CMD_RDEN[0] = 1'b1;
        step(1); CMD_RDEN[0] = 1'b0;
        step(4); CMD_EMPTY[0] = 1'b1;
        step(1); CMD_EMPTY[0] = 1'b0;
        step(10); IRQ_ACK[0] = 1'b1;
        step(1); IRQ_ACK[0] = 1'b0;
        step(7); CMD_EMPTY[0] = 1'b1;
        step(2);

        // 5a: DURATION=0 gives a single-cycle pulse on ch1
        step(1); b = cyc;
        DURATION = 32'd0;
        exp_at(b + 1, 4'h0, 4'h0, "t5_evt");
        exp_at(b + 2, 4'h2, 4'h0, "t5_one");
        exp_span(b + 3, b + 4, 4'h0, 4'h0, "t5_end");
        CMD_EMPTY[1] = 1'b0;
        step(5); CMD_EMPTY[1] = 1'b1;

        // 5b: masked ch3 with toggling EMPTY never fires, nothing left pending after unmask
        step(1); b = cyc;
        exp_span(b + 1, b + 12, 4'h0, 4'h0, "t5_mask");
        IRQ_MASK[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            CMD_EMPTY[3] = (i % 2 == 1);
            step(1);
        end
        IRQ_MASK[3] = 1'b0;
        step(5);

        // 6: async reset mid-pulse on all channels, then clean restart
        step(1); b = cyc;
        DURATION = 32'd20; IRQ_MODE = '0;
        exp_at(b + 1, 4'h0, 4'h0, "t6_evt");
        exp_span(b + 2, b + 5, 4'hF, 4'h0, "t6_all");
        CMD_EMPTY = 4'h0;
        step(6);
        #2;
        check("t6_pre_reset", {CMD_EMPTY_IMPULSE, IRQ_PENDING, IRQ_ANY}, {4'hF, 4'h0, 1'b1});
        RESET = 1'b1;
        #1;
        check("t6_async_drop", {CMD_EMPTY_IMPULSE, IRQ_PENDING, IRQ_ANY}, 9'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        b = cyc;
        exp_at(b + 1, 4'h0, 4'h0, "t6_restart_evt");
        exp_span(b + 2, b + 21, 4'hF, 4'h0, "t6_restart");
        exp_span(b + 22, b + 23, 4'h0, 4'h0, "t6_restart_end");
        step(24);
        CMD_EMPTY = 4'hF;

        for (int w = 0; w < 50 && sb_q.size() > 0; w++) step(1);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d snapshots never checked", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
